sram_arbiter: RTL and testbench

- Two-port arbiter that shares the single SRAM controller between requester 0 (pipeline MEM stage) and requester 1 (secondary master, e.g. a DMA or loader).
- Each requester uses the same level-held rd_en/wr_en/ready protocol the SRAM controller exposes.
- Grants are round-robin, or fixed-priority when selected by parameter.
- The arbiter latches the winning command, holds it on the controller until completion, registers the read data, and returns a one-cycle ready to the owner.

---
 rtl/sram_arbiter.sv | 136 +++++++++++++
 tb/tb_sram_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-requester arbiter in front of the single SRAM controller.
// Latches the winning command, holds it until sram_ready, returns one-cycle ready.
module sram_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_rd_en,
  input  logic                  m0_wr_en,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [DATA_WIDTH-1:0] m0_write_data,
  output logic                  m0_ready,
  output logic [DATA_WIDTH-1:0] m0_read_data,
  input  logic                  m1_rd_en,
  input  logic                  m1_wr_en,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [DATA_WIDTH-1:0] m1_write_data,
  output logic                  m1_ready,
  output logic [DATA_WIDTH-1:0] m1_read_data,
  output logic                  sram_rd_en,
  output logic                  sram_wr_en,
  output logic [ADDR_WIDTH-1:0] sram_address,
  output logic [DATA_WIDTH-1:0] sram_write_data,
  input  logic                  sram_ready,
  input  logic [DATA_WIDTH-1:0] sram_read_data
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic                  owner;
  logic                  last_grant;
  logic                  cmd_rd;
  logic                  cmd_wr;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  req0;
  logic                  req1;
  logic                  grant_id;
  logic                  win_rd;
  logic                  win_wr;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic                  do_grant;

  assign req0     = m0_rd_en | m0_wr_en;
  assign req1     = m1_rd_en | m1_wr_en;
  assign do_grant = (state == IDLE) && (req0 || req1);

  // A simultaneous rd/wr from one requester is treated as a write.
  always_comb begin
    grant_id = 1'b0;
    if (req0 && req1) begin
      grant_id = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant;
    end else begin
      grant_id = req1;
    end
  end

  always_comb begin
    win_rd    = m0_rd_en & ~m0_wr_en;
    win_wr    = m0_wr_en;
    win_addr  = m0_address;
    win_wdata = m0_write_data;
    if (grant_id) begin
      win_rd    = m1_rd_en & ~m1_wr_en;
      win_wr    = m1_wr_en;
      win_addr  = m1_address;
      win_wdata = m1_write_data;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req0 || req1) state_nxt = GRANT;
      GRANT:   if (sram_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      cmd_rd       <= 1'b0;
      cmd_wr       <= 1'b0;
      cmd_addr     <= '0;
      cmd_wdata    <= '0;
      m0_read_data <= '0;
      m1_read_data <= '0;
    end else begin
      if (do_grant) begin
        owner      <= grant_id;
        last_grant <= grant_id;
        cmd_rd     <= win_rd;
        cmd_wr     <= win_wr;
        cmd_addr   <= win_addr;
        cmd_wdata  <= win_wdata;
      end
      if (state == GRANT && sram_ready && cmd_rd) begin
        if (owner) begin
          m1_read_data <= sram_read_data;
        end else begin
          m0_read_data <= sram_read_data;
        end
      end
    end
  end

  assign sram_rd_en      = (state == GRANT) & cmd_rd;
  assign sram_wr_en      = (state == GRANT) & cmd_wr;
  assign sram_address    = cmd_addr;
  assign sram_write_data = cmd_wdata;

  assign m0_ready = ~req0 | ((state == DONE) & ~owner);
  assign m1_ready = ~req1 | ((state == DONE) & owner);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: round-robin and fixed-priority instances
// share stimulus and a 5-cycle controller model.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_rd_en = 1'b0;
  logic        m0_wr_en = 1'b0;
  logic [31:0] m0_address = '0;
  logic [31:0] m0_write_data = '0;
  logic        m1_rd_en = 1'b0;
  logic        m1_wr_en = 1'b0;
  logic [31:0] m1_address = '0;
  logic [31:0] m1_write_data = '0;
  logic [31:0] rdata = '0;
  logic        force_rdy = 1'b0;

  logic        m0_ready, m1_ready;
  logic [31:0] m0_read_data, m1_read_data;
  logic        sram_rd_en, sram_wr_en;
  logic [31:0] sram_address, sram_write_data;

  logic        fp_m0_ready, fp_m1_ready;
  logic [31:0] fp_m0_read_data, fp_m1_read_data;
  logic        fp_sram_rd_en, fp_sram_wr_en;
  logic [31:0] fp_sram_address, fp_sram_write_data;

  logic        mdl_rdy;
  logic        sram_ready;
  int          cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign sram_ready = mdl_rdy | force_rdy;

  sram_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIORITY(0)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_rd_en(m0_rd_en), .m0_wr_en(m0_wr_en),
    .m0_address(m0_address), .m0_write_data(m0_write_data),
    .m0_ready(m0_ready), .m0_read_data(m0_read_data),
    .m1_rd_en(m1_rd_en), .m1_wr_en(m1_wr_en),
    .m1_address(m1_address), .m1_write_data(m1_write_data),
    .m1_ready(m1_ready), .m1_read_data(m1_read_data),
    .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
    .sram_address(sram_address), .sram_write_data(sram_write_data),
    .sram_ready(sram_ready), .sram_read_data(rdata)
  );

  sram_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIORITY(1)
  ) dut_fp (
    .clk(clk), .rst(rst),
    .m0_rd_en(m0_rd_en), .m0_wr_en(m0_wr_en),
    .m0_address(m0_address), .m0_write_data(m0_write_data),
    .m0_ready(fp_m0_ready), .m0_read_data(fp_m0_read_data),
    .m1_rd_en(m1_rd_en), .m1_wr_en(m1_wr_en),
    .m1_address(m1_address), .m1_write_data(m1_write_data),
    .m1_ready(fp_m1_ready), .m1_read_data(fp_m1_read_data),
    .sram_rd_en(fp_sram_rd_en), .sram_wr_en(fp_sram_wr_en),
    .sram_address(fp_sram_address), .sram_write_data(fp_sram_write_data),
    .sram_ready(sram_ready), .sram_read_data(rdata)
  );

  // Controller model: ready one cycle, five cycles after enable rises.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_rdy <= 1'b0;
      cnt     <= 0;
    end else if (mdl_rdy) begin
      mdl_rdy <= 1'b0;
      cnt     <= 0;
    end else if (sram_rd_en | sram_wr_en) begin
      if (cnt == 4) mdl_rdy <= 1'b1;
      else cnt <= cnt + 1;
    end
  end

  typedef struct {
    logic        m0_rd;
    logic        m0_wr;
    logic [31:0] m0_addr;
    logic [31:0] m0_wd;
    logic        m1_rd;
    logic        m1_wr;
    logic [31:0] m1_addr;
    logic [31:0] m1_wd;
    logic [31:0] rd;
    logic        own;
    logic        e_rd;
    logic        e_wr;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic [31:0] e_r0;
    logic [31:0] e_r1;
  } vec_t;

  vec_t vt[9];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all();
    m0_rd_en = 1'b0;
    m0_wr_en = 1'b0;
    m1_rd_en = 1'b0;
    m1_wr_en = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int c;
    m0_rd_en      = v.m0_rd;
    m0_wr_en      = v.m0_wr;
    m0_address    = v.m0_addr;
    m0_write_data = v.m0_wd;
    m1_rd_en      = v.m1_rd;
    m1_wr_en      = v.m1_wr;
    m1_address    = v.m1_addr;
    m1_write_data = v.m1_wd;
    rdata         = v.rd;
    @(negedge clk);
    chk1("win_ready_c0", v.own ? m1_ready : m0_ready, 1'b0);
    next();
    @(negedge clk);
    chk1("grant_rd", sram_rd_en, v.e_rd);
    chk1("grant_wr", sram_wr_en, v.e_wr);
    chk32("grant_addr", sram_address, v.e_addr);
    chk32("grant_wdata", sram_write_data, v.e_wd);
    for (c = 2; c < 20; c++) begin
      next();
      @(negedge clk);
      if (v.own ? m1_ready : m0_ready) break;
      chk1("hold_en", sram_rd_en | sram_wr_en, 1'b1);
    end
    chk32("ready_latency", c, 32'd7);
    if (v.own ? (v.m0_rd | v.m0_wr) : (v.m1_rd | v.m1_wr))
      chk1("loser_wait", v.own ? m0_ready : m1_ready, 1'b0);
    drop_all();
    next();
    @(negedge clk);
    chk32("read_data0", m0_read_data, v.e_r0);
    chk32("read_data1", m1_read_data, v.e_r1);
    chk1("idle_en", sram_rd_en | sram_wr_en, 1'b0);
    next();
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
              32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0,
              32'hDEADBEEF, 32'h0};
    vt[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h100, 32'h12345678,
              32'hFEEDFACE, 1'b1, 1'b0, 1'b1, 32'h100, 32'h12345678,
              32'hDEADBEEF, 32'h0};
    vt[2] = '{1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0,
              32'hA5A50001, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0,
              32'hA5A50001, 32'h0};
    vt[3] = '{1'b1, 1'b0, 32'h204, 32'h0, 1'b1, 1'b0, 32'h304, 32'h0,
              32'h0BADF00D, 1'b1, 1'b1, 1'b0, 32'h304, 32'h0,
              32'hA5A50001, 32'h0BADF00D};
    vt[4] = '{1'b1, 1'b1, 32'h44, 32'hCAFEBABE, 1'b0, 1'b0, 32'h0, 32'h0,
              32'h11111111, 1'b0, 1'b0, 1'b1, 32'h44, 32'hCAFEBABE,
              32'hA5A50001, 32'h0BADF00D};
    vt[5] = '{1'b0, 1'b1, 32'h48, 32'h55, 1'b1, 1'b0, 32'h60, 32'h0,
              32'h77770000, 1'b1, 1'b1, 1'b0, 32'h60, 32'h0,
              32'hA5A50001, 32'h77770000};
    vt[6] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h64, 32'h0,
              32'h00008888, 1'b1, 1'b1, 1'b0, 32'h64, 32'h0,
              32'hA5A50001, 32'h00008888};
    vt[7] = '{1'b1, 1'b0, 32'h68, 32'h0, 1'b1, 1'b0, 32'h6C, 32'h0,
              32'h00000099, 1'b0, 1'b1, 1'b0, 32'h68, 32'h0,
              32'h00000099, 32'h00008888};
    vt[8] = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
              32'h2468ACE0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0,
              32'h2468ACE0, 32'h0};

    // Reset state
    @(negedge clk);
    chk1("rst_rd_en", sram_rd_en, 1'b0);
    chk1("rst_wr_en", sram_wr_en, 1'b0);
    chk32("rst_addr", sram_address, 32'h0);
    chk32("rst_wdata", sram_write_data, 32'h0);
    chk32("rst_rdata0", m0_read_data, 32'h0);
    chk32("rst_rdata1", m1_read_data, 32'h0);
    chk1("rst_ready0", m0_ready, 1'b1);
    chk1("rst_ready1", m1_ready, 1'b1);
    next();
    rst = 1'b0;
    next();

    for (int i = 0; i < 8; i++) run_vec(vt[i]);

    // Owner drops its read mid-transaction; ready in DONE is ignored
    m0_rd_en   = 1'b1;
    m0_address = 32'h80;
    rdata      = 32'h13579BDF;
    next();
    next();
    next();
    m0_rd_en = 1'b0;
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk);
      chk1("drop_hold_rd", sram_rd_en, 1'b1);
      chk1("drop_ready0", m0_ready, 1'b1);
      next();
    end
    force_rdy = 1'b1;
    rdata     = 32'hFFFFFFFF;
    @(negedge clk);
    chk1("drop_done_rd", sram_rd_en, 1'b0);
    next();
    force_rdy = 1'b0;
    @(negedge clk);
    chk32("drop_rdata0", m0_read_data, 32'h13579BDF);
    chk1("drop_no_grant", sram_rd_en | sram_wr_en, 1'b0);
    next();
    force_rdy = 1'b1;
    rdata     = 32'h0;
    @(negedge clk);
    chk1("idle_rdy_en", sram_rd_en | sram_wr_en, 1'b0);
    next();
    force_rdy = 1'b0;
    @(negedge clk);
    chk32("idle_rdy_rdata0", m0_read_data, 32'h13579BDF);
    next();

    // Sustained contention; m0 address moves while pending
    m0_rd_en   = 1'b1;
    m0_address = 32'h700;
    m1_rd_en   = 1'b1;
    m1_address = 32'h704;
    rdata      = 32'h5A5A0000;
    for (int c = 0; c < 24; c++) begin
      int ph;
      int k;
      ph = c % 8;
      k  = c / 8;
      if (c == 3) m0_address = 32'h710;
      @(negedge clk);
      chk1("fp_m1_starved", fp_m1_ready, 1'b0);
      chk1("fp_m0_ready", fp_m0_ready, ph == 7);
      chk1("rr_m1_ready", m1_ready, (ph == 7) && (k != 1));
      chk1("rr_m0_ready", m0_ready, (ph == 7) && (k == 1));
      if (ph >= 1 && ph <= 6) begin
        chk32("fp_addr", fp_sram_address, (k == 0) ? 32'h700 : 32'h710);
        chk32("rr_addr", sram_address, (k == 1) ? 32'h710 : 32'h704);
      end
      next();
    end
    drop_all();
    next();
    next();

    // Reset in cycle 4 of a write
    m1_wr_en      = 1'b1;
    m1_address    = 32'h500;
    m1_write_data = 32'hAAAA5555;
    next();
    @(negedge clk);
    chk1("pre_rst_wr", sram_wr_en, 1'b1);
    next();
    next();
    next();
    rst = 1'b1;
    #1;
    chk1("mid_rst_wr", sram_wr_en, 1'b0);
    chk1("mid_rst_rd", sram_rd_en, 1'b0);
    chk32("mid_rst_addr", sram_address, 32'h0);
    chk32("mid_rst_rdata0", m0_read_data, 32'h0);
    chk32("mid_rst_rdata1", m1_read_data, 32'h0);
    chk1("mid_rst_ready1", m1_ready, 1'b0);
    drop_all();
    next();
    rst = 1'b0;
    @(negedge clk);
    chk1("post_rst_ready1", m1_ready, 1'b1);
    chk1("post_rst_en", sram_rd_en | sram_wr_en, 1'b0);
    next();
    run_vec(vt[8]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
